// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter sharing one delay/pulse timer engine among NUM_REQ requesters.
// The granted job's mode and weight are latched; the engine drives a shared active-low output.
module delay_timer_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int WEIGHT_BIT_WIDTH = 8,
  parameter int ID_W             = $clog2(NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req,
  input  logic [2*NUM_REQ-1:0]                  req_mode,
  input  logic [WEIGHT_BIT_WIDTH*NUM_REQ-1:0]   req_weight,
  output logic [NUM_REQ-1:0]                    grant,
  output logic [ID_W-1:0]                       active_id,
  output logic                                  busy,
  output logic [NUM_REQ-1:0]                    done,
  output logic                                  err,
  output logic                                  delay_out_n
);

  localparam int unsigned NREQ = NUM_REQ;
  localparam logic [WEIGHT_BIT_WIDTH-1:0] ONE = WEIGHT_BIT_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PULSE, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [WEIGHT_BIT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WEIGHT_BIT_WIDTH-1:0] weight_q, weight_d;
  logic [1:0]                  mode_q, mode_d;
  logic [ID_W-1:0]             id_q, id_d;
  logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]          grant_q, grant_d;
  logic [ID_W-1:0]             active_id_q, active_id_d;
  logic                        busy_q, busy_d;
  logic [NUM_REQ-1:0]          done_q, done_d;
  logic                        err_q, err_d;
  logic                        dout_n_q, dout_n_d;

  logic [WEIGHT_BIT_WIDTH-1:0] wt_a [NUM_REQ];
  logic [1:0]                  md_a [NUM_REQ];
  logic                        found;
  logic [ID_W-1:0]             win;
  logic [ID_W-1:0]             cand;
  int unsigned                 idx;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      wt_a[i] = req_weight[i*WEIGHT_BIT_WIDTH +: WEIGHT_BIT_WIDTH];
      md_a[i] = req_mode[2*i +: 2];
    end
  end

  // First set request strictly after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx  = (32'(rr_ptr_q) + k) % NREQ;
      cand = ID_W'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    weight_d = weight_q;
    mode_d   = mode_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          id_d     = win;
          mode_d   = md_a[win];
          weight_d = wt_a[win];
          unique case (md_a[win])
            2'b00: begin
              if (wt_a[win] == '0) state_d = S_DONE;
              else begin
                state_d = S_PULSE;
                cnt_d   = wt_a[win] - ONE;
              end
            end
            2'b01: begin
              if (wt_a[win] == '0) begin
                state_d = S_PULSE;
                cnt_d   = '0;
              end else begin
                state_d = S_DELAY;
                cnt_d   = wt_a[win] - ONE;
              end
            end
            2'b10: begin
              if (wt_a[win] == '0) state_d = S_DONE;
              else begin
                state_d = S_DELAY;
                cnt_d   = wt_a[win] - ONE;
              end
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_DELAY: begin
        if (!req[id_q]) begin
          state_d  = S_IDLE;
          rr_ptr_d = id_q;
        end else if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = (mode_q == 2'b01) ? '0 : weight_q - ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_PULSE: begin
        if (!req[id_q]) begin
          state_d  = S_IDLE;
          rr_ptr_d = id_q;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        rr_ptr_d = id_q;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    busy_d      = (state_d != S_IDLE);
    grant_d     = '0;
    done_d      = '0;
    active_id_d = '0;
    if (busy_d) begin
      grant_d[id_d] = 1'b1;
      active_id_d   = id_d;
    end
    if (state_d == S_DONE) done_d[id_d] = 1'b1;
    err_d    = (state_d == S_DONE) && (mode_d == 2'b11);
    dout_n_d = (state_d != S_PULSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      weight_q    <= '0;
      mode_q      <= '0;
      id_q        <= '0;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      grant_q     <= '0;
      active_id_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= '0;
      err_q       <= 1'b0;
      dout_n_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      weight_q    <= weight_d;
      mode_q      <= mode_d;
      id_q        <= id_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      active_id_q <= active_id_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      dout_n_q    <= dout_n_d;
    end
  end

  assign grant       = grant_q;
  assign active_id   = active_id_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign delay_out_n = dout_n_q;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Bench for delay_timer_arbiter: a job-schedule model checked every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_delay_timer_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  localparam int K_IDLE  = 0;
  localparam int K_DELAY = 1;
  localparam int K_PULSE = 2;
  localparam int K_DONE  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [2*N-1:0]   req_mode;
  logic [W*N-1:0]   req_weight;
  logic [N-1:0]     grant;
  logic [IDW-1:0]   active_id;
  logic             busy;
  logic [N-1:0]     done;
  logic             err;
  logic             delay_out_n;

  int vectors     = 0;
  int miscompares = 0;

  delay_timer_arbiter #(.NUM_REQ(N), .WEIGHT_BIT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .req_weight(req_weight),
    .grant(grant), .active_id(active_id), .busy(busy), .done(done), .err(err),
    .delay_out_n(delay_out_n)
  );

  always #5 clk = ~clk;

  // Model: each accepted job expands into a per-cycle schedule of phases.
  typedef struct {int kind; int id; bit e;} item_t;
  item_t cur;
  item_t sched[$];
  int    m_ptr;
  bit    model_valid = 1'b0;
  int    cand;
  bit    picked;

  function automatic item_t mk(int kind, int id, bit e);
    item_t it;
    it.kind = kind; it.id = id; it.e = e;
    return it;
  endfunction

  function automatic void plan(int i);
    int m, w;
    m = int'(req_mode[2*i +: 2]);
    w = int'(req_weight[W*i +: W]);
    case (m)
      0: begin
        for (int c = 0; c < w; c++) sched.push_back(mk(K_PULSE, i, 1'b0));
      end
      1: begin
        for (int c = 0; c < w; c++) sched.push_back(mk(K_DELAY, i, 1'b0));
        sched.push_back(mk(K_PULSE, i, 1'b0));
      end
      2: begin
        for (int c = 0; c < w; c++) sched.push_back(mk(K_DELAY, i, 1'b0));
        for (int c = 0; c < w; c++) sched.push_back(mk(K_PULSE, i, 1'b0));
      end
      default: ;
    endcase
    sched.push_back(mk(K_DONE, i, m == 3));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      cur = mk(K_IDLE, 0, 1'b0);
      sched.delete();
      m_ptr = N - 1;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (cur.kind == K_IDLE) begin
        picked = 1'b0;
        for (int k = 1; k <= N; k++) begin
          cand = (m_ptr + k) % N;
          if (!picked && req[cand]) begin
            plan(cand);
            picked = 1'b1;
          end
        end
        if (sched.size() > 0) cur = sched.pop_front();
      end else if ((cur.kind == K_DELAY || cur.kind == K_PULSE) && !req[cur.id]) begin
        m_ptr = cur.id;
        cur = mk(K_IDLE, 0, 1'b0);
        sched.delete();
      end else if (cur.kind == K_DONE) begin
        m_ptr = cur.id;
        cur = mk(K_IDLE, 0, 1'b0);
      end else begin
        cur = sched.pop_front();
      end
    end
  end

  logic [N-1:0]   eg, ed;
  logic [IDW-1:0] eid;
  logic           eb, ee, eo;

  always @(negedge clk) begin
    if (model_valid) begin
      eb  = (cur.kind != K_IDLE);
      eg  = eb ? N'(1) << cur.id : '0;
      eid = eb ? IDW'(cur.id) : '0;
      ed  = (cur.kind == K_DONE) ? N'(1) << cur.id : '0;
      ee  = (cur.kind == K_DONE) && cur.e;
      eo  = (cur.kind != K_PULSE);
      vectors++;
      if ({grant, active_id, busy, done, err, delay_out_n} !== {eg, eid, eb, ed, ee, eo}) begin
        miscompares++;
        $display("FAIL cycle t=%0t got grant=%b id=%0d busy=%b done=%b err=%b dout_n=%b, want grant=%b id=%0d busy=%b done=%b err=%b dout_n=%b",
                 $time, grant, active_id, busy, done, err, delay_out_n, eg, eid, eb, ed, ee, eo);
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic wait_done(int i, string name);
    bit got = 1'b0;
    for (int c = 0; c < 600 && !got; c++) begin
      @(negedge clk);
      if (done[i]) got = 1'b1;
    end
    if (!got) timeout(name);
  endtask

  task automatic run_job(int i, int m, int w, output int hi, output int lo, output int e);
    bit got = 1'b0;
    req_mode[2*i +: 2] = 2'(m);
    req_weight[W*i +: W] = W'(w);
    req[i] = 1'b1;
    hi = 0; lo = 0; e = 0;
    for (int c = 0; c < 600 && !got; c++) begin
      @(negedge clk);
      if (done[i]) begin
        got = 1'b1;
        e = int'(err);
      end else if (grant[i]) begin
        if (delay_out_n) hi++;
        else lo++;
      end
    end
    if (!got) timeout("run_job");
    req[i] = 1'b0;
  endtask

  int hi, lo, e, lows, ndone, last_t;
  int order[6];
  int exp_order[6] = '{0, 1, 3, 0, 1, 3};
  bit ok;

  initial begin
    rst = 1'b1; req = '0; req_mode = '0; req_weight = '0;
    repeat (2) @(negedge clk);
    chk("reset dout_n", int'(delay_out_n), 1);
    chk("reset grant", int'(grant), 0);
    rst = 1'b0;

    // One-shot, weight 3
    req_mode[1:0] = 2'b00; req_weight[7:0] = 8'd3; req[0] = 1'b1;
    @(negedge clk);
    chk("t1 c1 grant", int'(grant), 1);
    chk("t1 c1 dout_n", int'(delay_out_n), 0);
    chk("t1 c1 busy", int'(busy), 1);
    @(negedge clk);
    @(negedge clk);
    chk("t1 c3 dout_n", int'(delay_out_n), 0);
    @(negedge clk);
    chk("t1 c4 done", int'(done), 1);
    chk("t1 c4 grant", int'(grant), 1);
    chk("t1 c4 dout_n", int'(delay_out_n), 1);
    req[0] = 1'b0;
    @(negedge clk);
    chk("t1 c5 busy", int'(busy), 0);
    chk("t1 c5 grant", int'(grant), 0);

    run_job(2, 1, 5, hi, lo, e);
    chk("m01 w5 high", hi, 5); chk("m01 w5 low", lo, 1); chk("m01 w5 err", e, 0);
    run_job(2, 2, 2, hi, lo, e);
    chk("m10 w2 high", hi, 2); chk("m10 w2 low", lo, 2);
    run_job(1, 0, 0, hi, lo, e);
    chk("m00 w0 high", hi, 0); chk("m00 w0 low", lo, 0);
    run_job(3, 1, 0, hi, lo, e);
    chk("m01 w0 high", hi, 0); chk("m01 w0 low", lo, 1);
    run_job(0, 3, 7, hi, lo, e);
    chk("m11 low", lo, 0); chk("m11 err", e, 1);

    // Round robin among 0,1,3 from a fresh reset
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    req_mode = '0;
    req_weight = {8'd1, 8'd1, 8'd1, 8'd1};
    req = 4'b1011;
    ndone = 0; last_t = 0;
    for (int c = 0; c < 100 && ndone < 6; c++) begin
      @(negedge clk);
      if (done != '0) begin
        for (int i = 0; i < N; i++) if (done[i]) order[ndone] = i;
        if (ndone > 0) chk("rr done spacing", c - last_t, 3);
        last_t = c;
        ndone++;
      end
    end
    req = '0;
    if (ndone < 6) timeout("round robin");
    for (int j = 0; j < 6; j++) chk("rr order", order[j], exp_order[j]);

    // Abort during pulse with a pending requester
    req_mode[3:2] = 2'b10; req_weight[15:8] = 8'd10;
    req_mode[5:4] = 2'b00; req_weight[23:16] = 8'd2;
    req = 4'b0110;
    lows = 0;
    for (int c = 0; c < 100 && lows < 3; c++) begin
      @(negedge clk);
      if (grant[1] && !delay_out_n) lows++;
    end
    if (lows < 3) timeout("abort pulse");
    req[1] = 1'b0;
    @(negedge clk);
    chk("abort dout_n", int'(delay_out_n), 1);
    chk("abort grant", int'(grant), 0);
    chk("abort done", int'(done), 0);
    @(negedge clk);
    chk("abort next grant", int'(grant), 4);
    wait_done(2, "pending job");
    req[2] = 1'b0;

    // Reset mid-pulse; afterwards arbitration restarts from index 0
    req_mode = '0;
    req_weight[7:0] = 8'd200;
    req = 4'b0001;
    repeat (5) @(negedge clk);
    chk("long pulse dout_n", int'(delay_out_n), 0);
    rst = 1'b1;
    req_weight[7:0] = 8'd1; req_weight[31:24] = 8'd1;
    req = 4'b1001;
    @(negedge clk);
    ok = (grant == '0) && (active_id == '0) && !busy && (done == '0) && !err && delay_out_n;
    chk("mid-job reset outputs", int'(ok), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset grant", int'(grant), 1);
    wait_done(0, "post-reset job0");
    req[0] = 1'b0;
    wait_done(3, "post-reset job3");
    req[3] = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/delay_timer_arbiter.md
Name: delay_timer_arbiter

Overview:
- Shares one programmable delay/pulse timer engine between NUM_REQ requesters.
- Round-robin arbitration. The winning request's mode and weight are latched, and the engine runs the delay and low-pulse phases on the shared active-low output.
- Signals completion per requester, then re-arbitrates.
- Sits between trigger sources (sensor or GPIO channels) and the single delay output pin.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WEIGHT_BIT_WIDTH, 8, width of each requester's weight and of the internal counter.
- ID_W, $clog2(NUM_REQ), width of active_id.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request, level; held high for the whole job.
- req_mode  in  2*NUM_REQ  per-requester mode; requester i uses bits [2i+1:2i].
- req_weight  in  WEIGHT_BIT_WIDTH*NUM_REQ  per-requester weight, slice i.
- grant  out  NUM_REQ  one-hot; high while requester's job is active.
- active_id  out  ID_W  index of the granted requester; 0 when idle.
- busy  out  1  engine not in IDLE.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse; reserved mode was accepted.
- delay_out_n  out  1  shared output, active low.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: grant=0, active_id=0, busy=0, done=0, err=0, delay_out_n=1. Internal state: FSM=IDLE, rr_ptr=NUM_REQ-1, counter=0.
- Reset mid-job: aborts immediately with no done pulse. delay_out_n=1 in the cycle after rst is sampled.
- All outputs are registered.
- FSM states: IDLE, DELAY, PULSE, DONE.
- IDLE:
  - If any req bit is high, pick the first set bit searching from rr_ptr+1 upward, with modulo wrap.
  - Latch that requester's mode and weight. Set grant and active_id next cycle.
  - Next state depends on mode and weight.
  - With no req, stay in IDLE.
- Modes, with w = latched weight:
  - 00 one-shot: PULSE for w cycles.
  - 01 delayed operate: DELAY for w cycles, then PULSE for 1 cycle.
  - 10 delayed dual: DELAY for w cycles, then PULSE for w cycles.
  - 11 reserved: go straight to DONE, err=1 in the DONE cycle, no pulse.
- Phase length 0 (w=0) skips that phase:
  - Mode 00 with w=0 goes IDLE to DONE.
  - Mode 10 with w=0 goes IDLE to DONE.
  - Mode 01 with w=0 goes IDLE to PULSE (1 cycle).
- Counter behaviour:
  - Loaded with (phase length - 1) on entering DELAY or PULSE.
  - Decrements each cycle. The phase ends in the cycle counter==0; the next state follows.
  - No wrap: the counter never decrements below 0.
- delay_out_n is 0 exactly in cycles where state==PULSE, and 1 otherwise.
- DONE is one cycle:
  - grant is still high. done[active_id]=1.
  - rr_ptr is set to active_id.
  - Next state is IDLE; grant=0 and busy=0 in the following cycle.
- Arbitration latency:
  - req sampled in IDLE in cycle N gives grant in cycle N+1.
  - Back-to-back jobs have exactly one IDLE cycle between a DONE and the next grant.
- Abort: if req[active_id] is low while in DELAY or PULSE:
  - Next state is IDLE. No done pulse.
  - delay_out_n=1 next cycle. rr_ptr is set to active_id.
- req, mode and weight changes of the active requester after acceptance are ignored, except the abort drop of req.
- Requests from non-granted requesters are held pending and are never lost while their req stays high.
- Fairness: any continuously asserted req is granted within NUM_REQ-1 jobs.
- done and err never assert outside the DONE state. At most one grant bit is high at any time.

Test Plan:
- Reset then req[0]=1, mode=00, weight=3 at cycle 0 -> grant[0]=1 cycles 1-4; delay_out_n=0 cycles 1-3; done[0]=1 cycle 4; busy=0 cycle 5.
- req[2]=1, mode=01, weight=5 -> delay_out_n=1 for 5 granted cycles, then 0 for exactly 1 cycle, then done[2] pulse; mode=10, weight=2 -> 2 high, 2 low, then done.
- req[0], req[1] and req[3] all held high, each mode=00, weight=1 -> grant order 0, 1, 3, 0, 1, 3; one IDLE cycle between each DONE and the next grant; never two grant bits high.
- Edge cases:
  - weight=0, mode=00 -> grant, done and IDLE with no low pulse.
  - weight=0, mode=01 -> single low cycle.
  - mode=11 -> err=1 together with done; delay_out_n stays 1.
- req[1], mode=10, weight=10 -> drop req[1] during PULSE cycle 3 -> delay_out_n=1 and IDLE next cycle, no done[1]; a pending req[2] is then granted next.
- rst=1 for 1 cycle during PULSE of a weight=200 job -> all outputs at reset values next cycle; a new req is accepted starting from index 0.
